// File: rtl/axi_sram_rd_slave.sv
// AXI read-only slave. Accepts one AR burst at a time and streams R beats from a
// synchronous single-port SRAM (one-cycle read latency). Illegal bursts are answered
// with SLVERR beats and never touch the SRAM.
module axi_sram_rd_slave #(
    parameter int unsigned IDS_W   = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDS_W-1:0]   ARID_S,
    input  logic [ADDR_W-1:0]  ARADDR_S,
    input  logic [LEN_W-1:0]   ARLEN_S,
    input  logic [2:0]         ARSIZE_S,
    input  logic [1:0]         ARBURST_S,
    input  logic               ARVALID_S,
    output logic               ARREADY_S,
    output logic [IDS_W-1:0]   RID_S,
    output logic [DATA_W-1:0]  RDATA_S,
    output logic [1:0]         RRESP_S,
    output logic               RLAST_S,
    output logic               RVALID_S,
    input  logic               RREADY_S,
    output logic               sram_cs,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [DATA_W-1:0]  sram_rdata
);

    typedef enum logic [1:0] {StIdle, StFetch, StData, StErr} state_t;

    state_t             state_q;
    logic [IDS_W-1:0]   id_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [1:0]         burst_q;
    logic [1:0]         resp_q;
    logic               arready_q;
    logic               rvalid_q;
    logic               fresh_q;   // SRAM output belongs to the beat on display
    logic [DATA_W-1:0]  hold_q;

    logic               ar_hs;
    logic               r_hs;
    logic               last;
    logic               ar_err;
    logic               wrap_len_ok;
    logic               fetch_next;
    logic [SRAM_AW-1:0] wrap_mask;
    logic [SRAM_AW-1:0] addr_inc;
    logic [SRAM_AW-1:0] addr_nxt;

    // Only the word-address bits are decoded here; the rest is handled upstream.
    logic unused_addr;
    assign unused_addr = ^{ARADDR_S[ADDR_W-1:SRAM_AW+2], ARADDR_S[1:0]};

    assign ar_hs      = ARVALID_S & arready_q;
    assign r_hs       = rvalid_q & RREADY_S;
    assign last       = (cnt_q == len_q);
    assign fetch_next = (state_q == StData) & r_hs & ~last;

    // Burst legality check and next-beat address generation.
    always_comb begin
        wrap_len_ok = 1'b0;
        case (ARLEN_S)
            LEN_W'(1), LEN_W'(3), LEN_W'(7), LEN_W'(15): wrap_len_ok = 1'b1;
            default:                                     wrap_len_ok = 1'b0;
        endcase
        ar_err = (ARSIZE_S != 3'b010) | (ARBURST_S == 2'b11) |
                 ((ARBURST_S == 2'b10) & ~wrap_len_ok);

        // Legal WRAP lengths are 2^k-1, so LEN itself is the wrap mask.
        wrap_mask = SRAM_AW'(len_q);
        addr_inc  = addr_q + SRAM_AW'(1);
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_nxt = addr_inc;
        endcase
    end

    // SRAM strobe and R-channel outputs; the next word is fetched in the handshake cycle.
    always_comb begin
        sram_cs   = (state_q == StFetch) | fetch_next;
        sram_addr = fetch_next ? addr_nxt : addr_q;
        RDATA_S   = '0;
        if (state_q == StData) begin
            RDATA_S = fresh_q ? sram_rdata : hold_q;
        end
        ARREADY_S = arready_q;
        RVALID_S  = rvalid_q;
        RLAST_S   = rvalid_q & last;
        RID_S     = id_q;
        RRESP_S   = resp_q;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            resp_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            fresh_q   <= 1'b0;
            hold_q    <= '0;
        end else begin
            fresh_q <= sram_cs;
            if ((state_q == StData) & fresh_q & ~r_hs) begin
                hold_q <= sram_rdata;
            end
            case (state_q)
                StIdle: begin
                    arready_q <= ~ar_hs;
                    if (ar_hs) begin
                        id_q    <= ARID_S;
                        addr_q  <= ARADDR_S[SRAM_AW+1:2];
                        len_q   <= ARLEN_S;
                        burst_q <= ARBURST_S;
                        cnt_q   <= '0;
                        if (ar_err) begin
                            resp_q   <= 2'b10;
                            rvalid_q <= 1'b1;
                            state_q  <= StErr;
                        end else begin
                            resp_q  <= 2'b00;
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    rvalid_q <= 1'b1;
                    state_q  <= StData;
                end
                default: begin
                    if (r_hs) begin
                        if (last) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                            if (state_q == StData) begin
                                addr_q <= addr_nxt;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Bench for axi_sram_rd_slave: directed corner bursts plus random bursts with random
// R backpressure, checked against a burst-level address/data model.
module tb_axi_sram_rd_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic        sram_cs;
    logic [13:0] sram_addr;
    logic [31:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    axi_sram_rd_slave dut (
        .clk        (clk),
        .rst        (rst),
        .ARID_S     (ARID_S),
        .ARADDR_S   (ARADDR_S),
        .ARLEN_S    (ARLEN_S),
        .ARSIZE_S   (ARSIZE_S),
        .ARBURST_S  (ARBURST_S),
        .ARVALID_S  (ARVALID_S),
        .ARREADY_S  (ARREADY_S),
        .RID_S      (RID_S),
        .RDATA_S    (RDATA_S),
        .RRESP_S    (RRESP_S),
        .RLAST_S    (RLAST_S),
        .RVALID_S   (RVALID_S),
        .RREADY_S   (RREADY_S),
        .sram_cs    (sram_cs),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unique content per word so a wrong address shows up as wrong data.
    function automatic logic [31:0] pat(input logic [13:0] a);
        return {2'b01, a, 2'b10, ~a};
    endfunction

    // SRAM model: one-cycle read latency.
    always_ff @(posedge clk) begin
        if (sram_cs) sram_rdata <= pat(sram_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {ARREADY_S, RVALID_S, RLAST_S, sram_cs, RRESP_S}, 0);
        check({tag, "_rid"}, RID_S, 0);
        check({tag, "_rdata"}, RDATA_S, 0);
        check({tag, "_saddr"}, sram_addr, 0);
    endtask

    // One burst: drive AR, then consume R beats while checking everything against the model.
    // RREADY is low in cycles stall_lo..stall_hi (relative to the AR handshake) and otherwise
    // low with probability stall_pct. abort_beat >= 0 asserts rst when that beat is on display.
    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int stall_pct,
                             input int stall_lo, input int stall_hi, input int abort_beat);
        logic [13:0] exp_a[16];
        logic [13:0] s;
        logic [13:0] base;
        logic [31:0] exp_d;
        logic [31:0] prev_data;
        logic        err;
        logic        prev_stall;
        int          n;
        int          beat;
        int          fetch;
        int          first;
        int          waitc;

        n   = int'(len) + 1;
        s   = addr[15:2];
        err = (size != 3'b010) || (burst == 2'b11) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        base = s - 14'(int'(s) % n);
        for (int k = 0; k < n; k++) begin
            case (burst)
                2'b00:   exp_a[k] = s;
                2'b10:   exp_a[k] = base + 14'((int'(s) % n + k) % n);
                default: exp_a[k] = s + 14'(k);
            endcase
        end

        @(negedge clk);
        ARID_S    = id;
        ARADDR_S  = addr;
        ARLEN_S   = len;
        ARSIZE_S  = size;
        ARBURST_S = burst;
        ARVALID_S = 1'b1;
        waitc = 0;
        while (!ARREADY_S && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!ARREADY_S) begin
            check("ar_timeout", 0, 1);
            ARVALID_S = 1'b0;
            return;
        end
        @(posedge clk);
        #1 ARVALID_S = 1'b0;

        beat       = 0;
        fetch      = 0;
        first      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc >= stall_lo && cyc <= stall_hi) RREADY_S = 1'b0;
            else RREADY_S = ($urandom_range(99) >= stall_pct);
            #1;
            if (cyc == 1) check("ar_busy", ARREADY_S, 0);
            if (err) begin
                check("err_cs", sram_cs, 0);
            end else if (sram_cs) begin
                if (fetch < n) check("saddr", sram_addr, exp_a[fetch]);
                else check("extra_fetch", 1, 0);
                fetch++;
            end
            if (prev_stall) begin
                check("rvalid_held", RVALID_S, 1);
                check("data_held", RDATA_S, prev_data);
            end
            if (RVALID_S) begin
                if (first == 0) first = cyc;
                if (beat == abort_beat) begin
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    RREADY_S = 1'b0;
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                exp_d = err ? 32'h0 : pat(exp_a[beat]);
                check("rid", RID_S, id);
                check("rresp", RRESP_S, err ? 2'b10 : 2'b00);
                check("rlast", RLAST_S, (beat == n - 1));
                check("rdata", RDATA_S, exp_d);
                if (!RREADY_S) check("stall_cs", sram_cs, 0);
                if (RREADY_S) beat++;
            end
            prev_stall = RVALID_S && !RREADY_S;
            prev_data  = RDATA_S;
            if (beat == n) break;
        end
        if (beat != n) begin
            check("beat_timeout", beat, n);
        end else begin
            check("latency", first, err ? 1 : 2);
            if (!err) check("fetch_cnt", fetch, n);
            @(negedge clk);
            RREADY_S = 1'b0;
            #1;
            check("ar_back", ARREADY_S, 1);
            check("rvalid_end", RVALID_S, 0);
        end
    endtask

    initial begin
        logic [3:0] rlen;
        logic [1:0] rburst;
        logic [2:0] rsize;

        rst       = 1'b1;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = 3'b010;
        ARBURST_S = 2'b01;
        ARVALID_S = 1'b0;
        RREADY_S  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_ready", ARREADY_S, 1);

        // INCR, no backpressure
        run_burst(8'h15, 32'h0000_0010, 4'd3, 3'b010, 2'b01, 0, 0, -1, -1);
        // Same burst stalled in cycles 2-4
        run_burst(8'h15, 32'h0000_0010, 4'd3, 3'b010, 2'b01, 0, 2, 4, -1);
        // WRAP from word 6: 6,7,4,5
        run_burst(8'h21, 32'h0000_0018, 4'd3, 3'b010, 2'b10, 0, 0, -1, -1);
        // FIXED at word 9
        run_burst(8'h02, 32'h0000_0024, 4'd2, 3'b010, 2'b00, 0, 0, -1, -1);
        // Error bursts
        run_burst(8'h33, 32'h0000_0040, 4'd1, 3'b001, 2'b01, 0, 0, -1, -1);
        run_burst(8'h34, 32'h0000_0040, 4'd0, 3'b010, 2'b11, 0, 0, -1, -1);
        run_burst(8'h35, 32'h0000_0040, 4'd2, 3'b010, 2'b10, 30, 0, -1, -1);
        // INCR across the top of the SRAM
        run_burst(8'h07, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01, 0, 0, -1, -1);
        // Reset during beat 2, then a clean burst
        run_burst(8'h11, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 0, 0, -1, 2);
        run_burst(8'h12, 32'h0000_0200, 4'd3, 3'b010, 2'b01, 0, 0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            rlen   = 4'($urandom_range(15));
            rburst = 2'($urandom_range(3));
            rsize  = ($urandom_range(9) == 0) ? 3'b001 : 3'b010;
            if (rburst == 2'b10 && $urandom_range(9) < 7) begin
                case ($urandom_range(3))
                    0:       rlen = 4'd1;
                    1:       rlen = 4'd3;
                    2:       rlen = 4'd7;
                    default: rlen = 4'd15;
                endcase
            end
            run_burst(8'($urandom), $urandom, rlen, rsize, rburst,
                      int'($urandom_range(60)), 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
